hough_peak_finder: RTL and testbench
====================================

# hough_peak_finder

Downstream stage of the Hough voting FSM. Once voting completes (its `ready` asserts), this block scans the full rho×theta accumulator RAM and reports the strongest line (rho, theta, votes) above a programmable threshold. As it reads each bin, it writes that bin back to zero, so the accumulator is clean for the next frame. It reads through a 1-cycle-latency RAM read port and clears through a separate write port of the same dual-port RAM.

## Interface
Parameters:
- `RHO_BINS`, default 1600: rho bins per theta row.
- `THETA_BINS`, default 181: theta rows (0..180 degrees).
- `RHO_OFFSET`, default 800: bias added to rho before it was stored.
- `COUNT_W`, default 16: vote counter width.
- `ADDR_W`, default 19: RAM address width. Must satisfy RHO_BINS×THETA_BINS ≤ 2^ADDR_W.

Ports (clock and reset first):
- `clock` in 1: system clock. Reset is `reset`, asynchronous, active-low; clock is `clock`.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: level sampled only in IDLE; a high sample starts a scan.
- `threshold` in COUNT_W: minimum vote count for a valid line. Sampled at start.
- `mem_rd_en` out 1: read strobe.
- `mem_rd_addr` out ADDR_W: read address, equal to theta×RHO_BINS + rho_idx.
- `mem_rd_data` in COUNT_W: read data, valid one cycle after `mem_rd_en`.
- `mem_wr_en` out 1: clear strobe.
- `mem_wr_addr` out ADDR_W: clear address.
- `mem_wr_data` out COUNT_W: constant 0.
- `busy` out 1: high from the cycle after start is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse when results are valid.
- `found` out 1: high if some bin is ≥ threshold.
- `peak_rho` out 11, signed: rho_idx − RHO_OFFSET.
- `peak_theta` out 8: theta row of the peak.
- `peak_votes` out COUNT_W: vote count of the peak.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
  - IDLE→SCAN when `start` is high; clears best registers and latches `threshold`.
  - SCAN→DRAIN after the address N−1 read is issued, where N = RHO_BINS×THETA_BINS.
  - DRAIN→DONE after the last data word is compared.
  - DONE→IDLE unconditionally.
- Address generation uses nested counters: rho_idx (inner, wraps at RHO_BINS−1) and theta_idx (outer). No divider.
- One read per SCAN cycle. There are no stalls or backpressure.
- Compare rule: a returned word updates best when data ≥ threshold_latched and data > best_votes (strict). On ties, the first bin in scan order wins.
- Clear: each returned word's address, delayed one cycle from the read, is written with 0 in the same cycle its data is compared. The read address and write address are therefore never equal in the same cycle.
- If no bin qualifies: `found`=0 and `peak_rho`/`peak_theta`/`peak_votes`=0.
- `start` while busy is ignored, with no queuing.
- Reset mid-scan drops immediately to IDLE and forces all outputs to their reset values. Bins not yet cleared keep their contents; the next start performs a full scan.
- Result outputs hold their values until the next accepted start, which zeroes them.

## Timing
- Reset values: every output is 0, and state is IDLE.
- Cycle 0: `start` is sampled high in IDLE.
- Cycle 1..N: `mem_rd_en`=1, with `mem_rd_addr` = k−1 in cycle k.
- Cycle 2..N+1: data for address k−2 is compared, and `mem_wr_en`=1 with `mem_wr_addr` = k−2.
- Cycle N+2: `done`=1 and results are valid. Results are registered, so they are stable in the same cycle as `done`.
- Total latency from start to done is N+2 cycles, which is 289602 at the defaults.
- `busy` is high in cycles 1..N+2. IDLE is re-entered at N+3, so the earliest next start is sampled at N+3.

## Structure
- Shared package `hough_pkg` holds:
  - `RHO_BINS`, `THETA_BINS`, `RHO_OFFSET`, `COUNT_W`, `ADDR_W`;
  - the state encoding (one-hot, matching the voting FSM style);
  - the `max_rho` bias constant, so it is used by both the voting FSM and this block.
- One sub-module is natural: `hough_bin_counter`, the nested rho/theta counter. It has `en` and `clr` inputs, and outputs `rho_idx`, `theta_idx`, a linear address, and a `last` flag.

## Test plan
Bench parameters: RHO_BINS=8, THETA_BINS=4, RHO_OFFSET=4, COUNT_W=8, so N=32. The RAM model is preloaded.
- Single peak: 9 at theta 2 / rho_idx 5 (addr 21), all other bins 1, threshold 3. Require `done` at cycle 34, `found`=1, `peak_theta`=2, `peak_rho`=1, `peak_votes`=9.
- Tie: 7 at addr 3 and at addr 20, threshold 2. Require `peak_theta`=0, `peak_rho`=−1, `peak_votes`=7.
- Below threshold: max bin 5 with threshold 6. Require `found`=0 and all peak outputs 0.
- Clear-after-read and latency: after any scan, all 32 RAM words are 0. An immediate second start at cycle 35 gives `found`=0 and `done` at cycle 69.
- Start while busy, then reset: `start` held high during SCAN has no effect, and `done` pulses exactly once. Reset asserted at cycle 10 drops `busy`, `mem_rd_en` and `mem_wr_en` to 0 immediately; the next start runs a full 34-cycle scan.
- Last-bin boundary: 255 at addr 31 (theta 3, rho_idx 7). Require `peak_theta`=3, `peak_rho`=3, `peak_votes`=255.

Source files
------------

// File: rtl/hough_pkg.sv
// hough_pkg
// Shared constants and types for the Hough transform blocks (voting FSM and
// peak finder). Holds the default accumulator geometry, the rho bias, the
// one-hot state encoding and the fixed output field widths.
package hough_pkg;

  // Rho values are biased by this amount before being used as a bin index,
  // so that negative rho maps onto the low end of the accumulator row.
  localparam int MAX_RHO    = 800;

  localparam int RHO_BINS   = 1600;
  localparam int THETA_BINS = 181;
  localparam int RHO_OFFSET = MAX_RHO;
  localparam int COUNT_W    = 16;
  localparam int ADDR_W     = 19;

  // Fixed widths of the reported peak coordinates.
  localparam int RHO_OUT_W  = 11;
  localparam int THETA_W    = 8;

  // One-hot encoding, same style as the voting FSM.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SCAN  = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

endpackage

// File: rtl/hough_bin_counter.sv
// hough_bin_counter
// Nested rho/theta scan counter for walking the accumulator in row-major
// order. A linear address is kept alongside the two indices so no
// multiplier is needed to form theta*RHO_BINS + rho_idx.
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   en                : advance one bin
//   clr               : return to bin 0 (priority over en)
//   rho_idx           : inner index, wraps at RHO_BINS-1
//   theta_idx         : outer index
//   addr              : linear address of the current bin
//   last              : current bin is the final bin of the accumulator
module hough_bin_counter #(
  parameter int RHO_BINS   = 1600,
  parameter int THETA_BINS = 181,
  parameter int RHO_W      = 11,
  parameter int THETA_W    = 8,
  parameter int ADDR_W     = 19
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  output logic [RHO_W-1:0]   rho_idx,
  output logic [THETA_W-1:0] theta_idx,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  logic rho_wrap;

  assign rho_wrap = (rho_idx == RHO_W'(RHO_BINS - 1));
  assign last     = rho_wrap && (theta_idx == THETA_W'(THETA_BINS - 1));

  // Stepping past the last bin wraps everything to zero so the counter is
  // already positioned for the next scan.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rho_idx   <= '0;
      theta_idx <= '0;
      addr      <= '0;
    end else if (clr) begin
      rho_idx   <= '0;
      theta_idx <= '0;
      addr      <= '0;
    end else if (en) begin
      if (last) begin
        rho_idx   <= '0;
        theta_idx <= '0;
        addr      <= '0;
      end else begin
        addr <= addr + ADDR_W'(1);
        if (rho_wrap) begin
          rho_idx   <= '0;
          theta_idx <= theta_idx + THETA_W'(1);
        end else begin
          rho_idx <= rho_idx + RHO_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/hough_peak_finder.sv
// hough_peak_finder
// Scans the whole rho x theta accumulator after voting, reports the
// strongest bin at or above a threshold, and zeroes every bin behind the
// read so the accumulator is clean for the next frame.
// Ports:
//   clock, reset               : clock, asynchronous active-low reset
//   start, threshold           : start request (sampled in IDLE) and vote threshold
//   mem_rd_en/addr/data        : 1-cycle-latency accumulator read port
//   mem_wr_en/addr/data        : accumulator clear port (data always 0)
//   busy, done                 : scan in progress / one-cycle result strobe
//   found, peak_rho/theta/votes: best bin found by the last scan
module hough_peak_finder #(
  parameter int RHO_BINS   = hough_pkg::RHO_BINS,
  parameter int THETA_BINS = hough_pkg::THETA_BINS,
  parameter int RHO_OFFSET = hough_pkg::RHO_OFFSET,
  parameter int COUNT_W    = hough_pkg::COUNT_W,
  parameter int ADDR_W     = hough_pkg::ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [COUNT_W-1:0]  threshold,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [COUNT_W-1:0]  mem_rd_data,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [COUNT_W-1:0]  mem_wr_data,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic signed [10:0]  peak_rho,
  output logic [7:0]          peak_theta,
  output logic [COUNT_W-1:0]  peak_votes
);

  import hough_pkg::*;

  localparam int RHO_W = (RHO_BINS > 1) ? $clog2(RHO_BINS) : 1;

  state_t               state, next_state;
  logic                 start_accept;
  logic                 scan_last;
  logic [RHO_W-1:0]     rho_idx;
  logic [THETA_W-1:0]   theta_idx;
  logic [ADDR_W-1:0]    scan_addr;
  logic [COUNT_W-1:0]   threshold_q;
  logic                 rd_valid;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [RHO_W-1:0]     rd_rho_q;
  logic [THETA_W-1:0]   rd_theta_q;
  logic                 hit;

  assign start_accept = (state == IDLE) && start;

  hough_bin_counter #(
    .RHO_BINS   (RHO_BINS),
    .THETA_BINS (THETA_BINS),
    .RHO_W      (RHO_W),
    .THETA_W    (THETA_W),
    .ADDR_W     (ADDR_W)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .en        (state == SCAN),
    .clr       (start_accept),
    .rho_idx   (rho_idx),
    .theta_idx (theta_idx),
    .addr      (scan_addr),
    .last      (scan_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SCAN;
      SCAN:    if (scan_last) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign mem_rd_en   = (state == SCAN);
  assign mem_rd_addr = scan_addr;
  assign mem_wr_en   = rd_valid;
  assign mem_wr_addr = rd_addr_q;
  assign mem_wr_data = '0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // Delay the read address and indices by the RAM latency so they line up
  // with the returned word; the same delayed address drives the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid   <= 1'b0;
      rd_addr_q  <= '0;
      rd_rho_q   <= '0;
      rd_theta_q <= '0;
    end else begin
      rd_valid   <= mem_rd_en;
      rd_addr_q  <= scan_addr;
      rd_rho_q   <= rho_idx;
      rd_theta_q <= theta_idx;
    end
  end

  // The first qualifying word is always taken, even if it equals zero with
  // a zero threshold; afterwards only a strictly larger count replaces it,
  // so ties keep the earliest bin in scan order.
  assign hit = rd_valid && (mem_rd_data >= threshold_q) &&
               (!found || (mem_rd_data > peak_votes));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      threshold_q <= '0;
      found       <= 1'b0;
      peak_rho    <= '0;
      peak_theta  <= '0;
      peak_votes  <= '0;
    end else if (start_accept) begin
      threshold_q <= threshold;
      found       <= 1'b0;
      peak_rho    <= '0;
      peak_theta  <= '0;
      peak_votes  <= '0;
    end else if (hit) begin
      found      <= 1'b1;
      peak_votes <= mem_rd_data;
      peak_theta <= rd_theta_q;
      peak_rho   <= 11'(rd_rho_q) - 11'(RHO_OFFSET);
    end
  end

endmodule

// File: tb/tb_hough_peak_finder.sv
// tb_hough_peak_finder
// Self-checking bench for hough_peak_finder on a small 8x4 accumulator.
// A behavioural dual-port RAM model sits on the DUT memory ports; expected
// results come from a reference scan of the preloaded image and are queued
// when each start is driven, then popped when done is seen.
module tb_hough_peak_finder;

  localparam int RHO_BINS   = 8;
  localparam int THETA_BINS = 4;
  localparam int RHO_OFFSET = 4;
  localparam int COUNT_W    = 8;
  localparam int ADDR_W     = 5;
  localparam int N          = RHO_BINS * THETA_BINS;

  typedef struct {
    logic              f;
    logic signed [10:0] rho;
    logic [7:0]        theta;
    logic [7:0]        votes;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         threshold = '0;
  logic               mem_rd_en;
  logic [4:0]         mem_rd_addr;
  logic [7:0]         mem_rd_data;
  logic               mem_wr_en;
  logic [4:0]         mem_wr_addr;
  logic [7:0]         mem_wr_data;
  logic               busy;
  logic               done;
  logic               found;
  logic signed [10:0] peak_rho;
  logic [7:0]         peak_theta;
  logic [7:0]         peak_votes;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [7:0] ram   [N];
  logic [7:0] image [N];
  logic       load_req = 1'b0;
  logic [7:0] rd_data_q;
  exp_t       exp_q [$];

  hough_peak_finder #(
    .RHO_BINS   (RHO_BINS),
    .THETA_BINS (THETA_BINS),
    .RHO_OFFSET (RHO_OFFSET),
    .COUNT_W    (COUNT_W),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .threshold   (threshold),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .peak_rho    (peak_rho),
    .peak_theta  (peak_theta),
    .peak_votes  (peak_votes)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Dual-port RAM model: 1-cycle read latency, separate write port, and a
  // bulk preload path from the image array.
  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) ram[i] <= image[i];
    end else if (mem_wr_en) begin
      ram[mem_wr_addr] <= mem_wr_data;
    end
    if (mem_rd_en) rd_data_q <= ram[mem_rd_addr];
  end

  assign mem_rd_data = rd_data_q;

  // Reference scan: first bin at or above threshold, then strictly larger.
  function automatic exp_t model(input logic [7:0] thr);
    exp_t e;
    e.f = 1'b0; e.rho = '0; e.theta = '0; e.votes = '0;
    for (int a = 0; a < N; a++) begin
      if (image[a] >= thr && (!e.f || image[a] > e.votes)) begin
        e.f     = 1'b1;
        e.votes = image[a];
        e.theta = 8'(a / RHO_BINS);
        e.rho   = 11'((a % RHO_BINS) - RHO_OFFSET);
      end
    end
    return e;
  endfunction

  task automatic fill_image(input logic [7:0] v);
    for (int i = 0; i < N; i++) image[i] = v;
  endtask

  task automatic load_ram;
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
  endtask

  // Starts a scan in the current cycle (cycle 0) and follows it through
  // cycle N+3, checking the memory strobes cycle by cycle and the results
  // against the scoreboard when done appears.
  task automatic run_scan(input logic [7:0] thr, input bit hold, output int done_abs);
    exp_t e;
    int   bad_rd, bad_wr, bad_busy, done_cnt, done_k;
    logic wr_on;
    bad_rd = 0; bad_wr = 0; bad_busy = 0; done_cnt = 0; done_k = -1; done_abs = -1;
    e.f = 1'b0; e.rho = '0; e.theta = '0; e.votes = '0;
    start     = 1'b1;
    threshold = thr;
    exp_q.push_back(model(thr));
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clock);
      if (!hold || k >= N + 2) start = 1'b0;
      if (mem_rd_en !== (k <= N) || ((k <= N) && mem_rd_addr !== 5'(k - 1))) bad_rd++;
      wr_on = (k >= 2) && (k <= N + 1);
      if (mem_wr_en !== wr_on ||
          (wr_on && (mem_wr_addr !== 5'(k - 2) || mem_wr_data !== 8'd0))) bad_wr++;
      if (busy !== (k <= N + 2)) bad_busy++;
      if (done === 1'b1) begin
        done_cnt++;
        done_k   = k;
        done_abs = cycle;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_empty: got done with no expected entry, required 1 entry");
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (found !== e.f) begin
            errors++;
            $display("[TB] FAIL found: got %0d required %0d", found, e.f);
          end
          checks++;
          if (peak_votes !== e.votes) begin
            errors++;
            $display("[TB] FAIL peak_votes: got %0d required %0d", peak_votes, e.votes);
          end
          checks++;
          if (peak_theta !== e.theta) begin
            errors++;
            $display("[TB] FAIL peak_theta: got %0d required %0d", peak_theta, e.theta);
          end
          checks++;
          if (peak_rho !== e.rho) begin
            errors++;
            $display("[TB] FAIL peak_rho: got %0d required %0d", peak_rho, e.rho);
          end
        end
      end
      if (k == N + 3 && done_k > 0) begin
        checks++;
        if (found !== e.f || peak_votes !== e.votes || peak_theta !== e.theta || peak_rho !== e.rho) begin
          errors++;
          $display("[TB] FAIL result_hold: got votes %0d theta %0d rho %0d, required votes %0d theta %0d rho %0d",
                   peak_votes, peak_theta, peak_rho, e.votes, e.theta, e.rho);
        end
      end
    end
    checks++;
    if (bad_rd !== 0) begin
      errors++;
      $display("[TB] FAIL rd_sequence: got %0d bad cycles, required 0", bad_rd);
    end
    checks++;
    if (bad_wr !== 0) begin
      errors++;
      $display("[TB] FAIL wr_sequence: got %0d bad cycles, required 0", bad_wr);
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++;
      $display("[TB] FAIL busy: got %0d bad cycles, required 0", bad_busy);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL done_count: got %0d pulses, required 1", done_cnt);
    end
    checks++;
    if (done_k !== N + 2) begin
      errors++;
      $display("[TB] FAIL done_cycle: got cycle %0d, required %0d", done_k, N + 2);
    end
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic check_ram_clear(input string name);
    int nz;
    nz = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== 8'd0) nz++;
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d nonzero words, required 0", name, nz);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, found, mem_rd_en, mem_wr_en} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, required 00000", {busy, done, found, mem_rd_en, mem_wr_en});
    end
    checks++;
    if (peak_rho !== 11'sd0 || peak_theta !== 8'd0 || peak_votes !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_peak: got rho %0d theta %0d votes %0d, required 0 0 0",
               peak_rho, peak_theta, peak_votes);
    end
    checks++;
    if (mem_rd_addr !== 5'd0 || mem_wr_addr !== 5'd0 || mem_wr_data !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_mem: got rd %0d wr %0d data %0d, required 0 0 0",
               mem_rd_addr, mem_wr_addr, mem_wr_data);
    end
  endtask

  task automatic test_single_peak;
    int d;
    fill_image(8'd1);
    image[21] = 8'd9;
    load_ram;
    run_scan(8'd3, 1'b0, d);
    check_ram_clear("clear_single_peak");
  endtask

  task automatic test_tie;
    int d;
    fill_image(8'd1);
    image[3]  = 8'd7;
    image[20] = 8'd7;
    load_ram;
    run_scan(8'd2, 1'b0, d);
  endtask

  task automatic test_below_threshold;
    int d;
    fill_image(8'd1);
    image[9]  = 8'd5;
    image[30] = 8'd5;
    load_ram;
    run_scan(8'd6, 1'b0, d);
  endtask

  task automatic test_back_to_back;
    int t0, d1, d2;
    fill_image(8'd0);
    image[10] = 8'd4;
    image[17] = 8'd6;
    load_ram;
    t0 = cycle;
    run_scan(8'd1, 1'b0, d1);
    fill_image(8'd0);
    run_scan(8'd1, 1'b0, d2);
    checks++;
    if (d1 - t0 !== 34) begin
      errors++;
      $display("[TB] FAIL b2b_first_done: got cycle %0d, required 34", d1 - t0);
    end
    checks++;
    if (d2 - t0 !== 69) begin
      errors++;
      $display("[TB] FAIL b2b_second_done: got cycle %0d, required 69", d2 - t0);
    end
    check_ram_clear("clear_back_to_back");
  endtask

  task automatic test_start_while_busy;
    int d;
    fill_image(8'd2);
    image[12] = 8'd8;
    load_ram;
    run_scan(8'd5, 1'b1, d);
  endtask

  task automatic test_reset_mid_scan;
    int d;
    fill_image(8'd1);
    image[2]  = 8'd50;
    image[20] = 8'd30;
    load_ram;
    start     = 1'b1;
    threshold = 8'd2;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, mem_rd_en, mem_wr_en} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midscan_reset_strobes: got %b, required 000", {busy, mem_rd_en, mem_wr_en});
    end
    checks++;
    if (found !== 1'b0 || peak_votes !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midscan_reset_result: got found %0d votes %0d, required 0 0", found, peak_votes);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (ram[8] !== 8'd1 || ram[20] !== 8'd30) begin
      errors++;
      $display("[TB] FAIL midscan_uncleared: got ram8 %0d ram20 %0d, required 1 30", ram[8], ram[20]);
    end
    for (int i = 0; i < 8; i++) image[i] = 8'd0;
    run_scan(8'd2, 1'b0, d);
    check_ram_clear("clear_after_rescan");
  endtask

  task automatic test_last_bin;
    int d;
    fill_image(8'd1);
    image[0]  = 8'd254;
    image[31] = 8'd255;
    load_ram;
    run_scan(8'd3, 1'b0, d);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clock);
    test_reset;
    reset = 1'b1;
    @(negedge clock);
    test_single_peak;
    test_tie;
    test_below_threshold;
    test_back_to_back;
    test_start_while_busy;
    test_reset_mid_scan;
    test_last_bin;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
